// File: rtl/spi_slave_ctrl_v2.sv
// spi_slave_ctrl_v2 -- SPI (mode 0) slave controller with burst register-file access.
//
// The whole block runs on CLK. SCLK, CS and MOSI are oversampled through 2-FF
// synchronizers. A transaction is an opcode field, then an optional address
// field, then any number of data words:
//   OP_WRITE : opcode, address, data words written to the register file
//   OP_READ  : opcode, address, data words shifted out on MISO
//   OP_STATUS: opcode, status words {ERR, WRAP, 0...} shifted out on MISO
// Any other opcode sets the sticky ERR flag, and the rest of the frame is ignored.
// The address auto-increments after every data word and wraps from ADDR_MAX to 0.
//
// Ports:
//   CLK, RST   system clock, synchronous active-high reset
//   SCLK, CS   SPI clock and active-low chip select (asynchronous)
//   MOSI       SPI data in, MSB first, sampled on SCLK rise
//   MISO       SPI data out, MSB first, updated on SCLK fall
//   MEM_ADDR   register-file address (registered)
//   MEM_WDATA  register-file write data (registered)
//   MEM_WE     one-CLK write strobe
//   MEM_RDATA  register-file read data, combinational from MEM_ADDR
//   BUSY       high while the FSM is not idle
//   ERR        sticky illegal-opcode flag
module spi_slave_ctrl_v2 #(
  parameter int               CMD_W     = 8,
  parameter int               ADDR_W    = 8,
  parameter int               DATA_W    = 8,
  parameter int               ADDR_MAX  = 255,
  parameter logic [CMD_W-1:0] OP_WRITE  = CMD_W'(8'h02),
  parameter logic [CMD_W-1:0] OP_READ   = CMD_W'(8'h03),
  parameter logic [CMD_W-1:0] OP_STATUS = CMD_W'(8'h05)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic              ERR
);

  // The input shift register is wide enough for the widest field.
  localparam int MAXW0 = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
  localparam int MAXW  = (MAXW0 > DATA_W) ? MAXW0 : DATA_W;
  localparam int CW    = $clog2(MAXW + 1);

  localparam logic [CW-1:0]     CMD_LAST  = CW'(CMD_W - 1);
  localparam logic [CW-1:0]     ADDR_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0]     DATA_LAST = CW'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] AMAX      = ADDR_W'(ADDR_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WR, S_RD, S_STAT, S_DISC
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_q;
  logic       cs_hi, mosi_b, sclk_rise, sclk_fall;

  // CS resets to the deselected level, so a reset never starts a frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], SCLK};
      cs_sync   <= {cs_sync[0], CS};
      mosi_sync <= {mosi_sync[0], MOSI};
      sclk_q    <= sclk_sync[1];
    end
  end

  assign cs_hi  = cs_sync[1];
  assign mosi_b = mosi_sync[1];
  // A deselect in the same cycle as an SCLK edge takes priority: mask the edge.
  assign sclk_rise = sclk_sync[1] & ~sclk_q & ~cs_hi;
  assign sclk_fall = ~sclk_sync[1] & sclk_q & ~cs_hi;

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  logic [CW-1:0]     bit_cnt;
  logic [MAXW-1:0]   in_shift;
  logic [DATA_W-1:0] out_shift;
  logic [ADDR_W-1:0] addr_reg;
  logic              wrap_q;
  logic              is_read;
  logic              load_pending;
  logic              inc_pending;

  // Field decode and helpers
  logic [CW-1:0]     last_idx;
  logic              field_done;
  logic [MAXW-1:0]   shift_nxt;
  logic [CMD_W-1:0]  opcode;
  logic              op_rw;
  logic              addr_wraps;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] status_word;

  always_comb begin
    case (state)
      S_CMD:   last_idx = CMD_LAST;
      S_ADDR:  last_idx = ADDR_LAST;
      default: last_idx = DATA_LAST;
    endcase
    field_done = sclk_rise && (bit_cnt == last_idx);
    // Word assembled from the register plus the bit arriving on this rise.
    shift_nxt  = {in_shift[MAXW-2:0], mosi_b};
    opcode     = shift_nxt[CMD_W-1:0];
    op_rw      = (opcode == OP_READ) || (opcode == OP_WRITE);
    // Out-of-range start addresses are used as-is; the next step wraps to 0.
    addr_wraps = (addr_reg >= AMAX);
    addr_inc   = addr_wraps ? '0 : addr_reg + ADDR_W'(1);
    status_word             = '0;
    status_word[DATA_W-1]   = ERR;
    status_word[DATA_W-2]   = wrap_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) begin
      if (!cs_hi) state_nxt = S_CMD;
    end else if (cs_hi) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_CMD: if (field_done) begin
          if (op_rw)                    state_nxt = S_ADDR;
          else if (opcode == OP_STATUS) state_nxt = S_STAT;
          else                          state_nxt = S_DISC;
        end
        S_ADDR: if (field_done) state_nxt = is_read ? S_RD : S_WR;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    BUSY = (state != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt      <= '0;
      in_shift     <= '0;
      out_shift    <= '0;
      addr_reg     <= '0;
      MEM_ADDR     <= '0;
      MEM_WDATA    <= '0;
      MEM_WE       <= 1'b0;
      MISO         <= 1'b0;
      ERR          <= 1'b0;
      wrap_q       <= 1'b0;
      is_read      <= 1'b0;
      load_pending <= 1'b0;
      inc_pending  <= 1'b0;
    end else begin
      MEM_WE       <= 1'b0;
      load_pending <= 1'b0;

      if (cs_hi && state != S_IDLE) begin
        // Deselect: drop any partial field; a scheduled write still completes.
        bit_cnt  <= '0;
        in_shift <= '0;
        MISO     <= 1'b0;
      end else begin
        if (sclk_rise && state inside {S_CMD, S_ADDR, S_WR, S_RD, S_STAT}) begin
          in_shift <= field_done ? '0 : shift_nxt;
          bit_cnt  <= field_done ? '0 : bit_cnt + CW'(1);
        end

        case (state)
          S_IDLE, S_DISC: begin
            MISO    <= 1'b0;
            bit_cnt <= '0;
          end
          S_CMD: if (field_done) begin
            is_read <= (opcode == OP_READ);
            if (opcode == OP_STATUS) load_pending <= 1'b1;
            else if (!op_rw)         ERR          <= 1'b1;
          end
          S_ADDR: if (field_done) begin
            addr_reg     <= shift_nxt[ADDR_W-1:0];
            MEM_ADDR     <= shift_nxt[ADDR_W-1:0];
            load_pending <= is_read;
          end
          S_WR: if (field_done) begin
            MEM_WDATA   <= shift_nxt[DATA_W-1:0];
            MEM_WE      <= 1'b1;
            inc_pending <= 1'b1;
          end
          S_RD: if (field_done) begin
            // Advance and prefetch so the next word is ready before the next fall.
            addr_reg     <= addr_inc;
            MEM_ADDR     <= addr_inc;
            load_pending <= 1'b1;
            if (addr_wraps) wrap_q <= 1'b1;
          end
          S_STAT: if (field_done) begin
            ERR          <= 1'b0;
            wrap_q       <= 1'b0;
            load_pending <= 1'b1;
          end
          default: ;
        endcase

        if ((state == S_RD || state == S_STAT) && sclk_fall) begin
          MISO      <= out_shift[DATA_W-1];
          out_shift <= {out_shift[DATA_W-2:0], 1'b0};
        end
      end

      // Load the word fetched for the current address (or the status word).
      if (load_pending)
        out_shift <= (state == S_RD) ? MEM_RDATA : status_word;

      // Post-write increment runs in the cycle MEM_WE is high, after the strobe
      // has used the current address. Placed last so a set beats a same-cycle clear.
      if (inc_pending) begin
        inc_pending <= 1'b0;
        addr_reg    <= addr_inc;
        MEM_ADDR    <= addr_inc;
        if (addr_wraps) wrap_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl_v2.sv
// Directed bench for spi_slave_ctrl_v2: an SPI master model driving frames,
// a behavioural register file, and scoreboard queues for writes and read bytes.
module tb_spi_slave_ctrl_v2;

  localparam int HALF = 5;  // SCLK half period in CLK cycles

  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi;
  logic       miso, mem_we, busy, err;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;

  logic [7:0]  mem     [256];
  bit          mem_vld [256];
  logic [15:0] obs_wr[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  always #5 clk = ~clk;

  spi_slave_ctrl_v2 dut (
    .CLK(clk), .RST(rst), .SCLK(sclk), .CS(cs), .MOSI(mosi), .MISO(miso),
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WE(mem_we),
    .MEM_RDATA(mem_rdata), .BUSY(busy), .ERR(err)
  );

  // Register file: unwritten locations read back addr ^ 8'h5C.
  assign mem_rdata = mem_vld[mem_addr] ? mem[mem_addr] : (mem_addr ^ 8'h5C);

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
      obs_wr.push_back({mem_addr, mem_wdata});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits of tx (MSB first); MISO is sampled at the end of each high phase.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      clks(HALF);
      sclk = 1'b1;
      clks(HALF - 1);
      rx[i] = miso;
      clks(1);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_start();
    cs = 1'b0;
    clks(6);
  endtask

  task automatic spi_end();
    clks(HALF);
    cs = 1'b1;
    clks(8);
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
  endtask

  // Clock one word out; the expected value was queued by the caller.
  task automatic recv(input string tag, input logic [7:0] tx);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
    if (exp_rd.size() == 0) check({tag, "_noexp"}, 32'd1, 32'd0);
    else check(tag, rx, exp_rd.pop_front());
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    while (obs_wr.size() > 0 && exp_wr.size() > 0)
      check({tag, "_wr"}, obs_wr.pop_front(), exp_wr.pop_front());
    obs_wr.delete();
    exp_wr.delete();
  endtask

  task automatic write2(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] a1);
    exp_wr.push_back({a, d0});
    exp_wr.push_back({a1, d1});
    spi_start();
    send(8'h02); send(a); send(d0); send(d1);
  endtask

  initial begin
    logic [7:0] rx;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    clks(4);
    rst = 1'b0;
    clks(3);
    check("rst_ctl", {miso, mem_we, busy, err}, 4'b0000);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_wdata", mem_wdata, 8'h00);

    // Reset in the middle of a write word
    spi_start();
    send(8'h02); send(8'h30);
    spi_bits(8'hA5, 4, rx);
    check("t1_busy", busy, 1'b1);
    rst = 1'b1; cs = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(4);
    check("t1_ctl", {miso, mem_we, busy, err}, 4'b0000);
    check("t1_addr", mem_addr, 8'h00);
    check("t1_nowr", obs_wr.size(), 0);

    // Two-word burst write
    write2(8'h10, 8'hA5, 8'h3C, 8'h11);
    check("t2_busy", busy, 1'b1);
    spi_end();
    check("t2_idle", busy, 1'b0);
    check_writes("t2");

    // Burst read of two words
    write2(8'h10, 8'h5A, 8'hC3, 8'h11);
    spi_end();
    check_writes("t3pre");
    spi_start();
    send(8'h03); send(8'h10);
    exp_rd.push_back(8'h5A); recv("t3_rd0", 8'h00);
    exp_rd.push_back(8'hC3); recv("t3_rd1", 8'h00);
    spi_end();

    spi_start();
    send(8'h05);
    exp_rd.push_back(8'h00); recv("t3_stat", 8'h00);
    spi_end();

    // Wrap at ADDR_MAX on write and on read, then status
    write2(8'hFF, 8'h11, 8'h22, 8'h00);
    spi_end();
    check_writes("t4pre");
    spi_start();
    send(8'h03); send(8'hFF);
    exp_rd.push_back(8'h11); recv("t4_rdff", 8'h00);
    exp_rd.push_back(8'h22); recv("t4_rd00", 8'h00);
    spi_end();
    spi_start();
    send(8'h05);
    exp_rd.push_back(8'h40); recv("t4_stat0", 8'h00);
    exp_rd.push_back(8'h00); recv("t4_stat1", 8'h00);
    spi_end();

    // Illegal opcode
    spi_start();
    send(8'h77);
    exp_rd.push_back(8'h00); recv("t5_disc0", 8'hFF);
    exp_rd.push_back(8'h00); recv("t5_disc1", 8'hA5);
    check("t5_err", err, 1'b1);
    spi_end();
    check_writes("t5");
    spi_start();
    send(8'h05);
    exp_rd.push_back(8'h80); recv("t5_stat0", 8'h00);
    exp_rd.push_back(8'h00); recv("t5_stat1", 8'h00);
    spi_end();
    check("t5_errclr", err, 1'b0);

    // Partial write word is dropped
    spi_start();
    send(8'h02); send(8'h20);
    spi_bits(8'hE7, 5, rx);
    spi_end();
    check_writes("t6");
    check("t6_addr", mem_addr, 8'h20);
    spi_start();
    send(8'h03); send(8'h20);
    exp_rd.push_back(8'h7C); recv("t6_rd", 8'h00);
    spi_end();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
